// File: rtl/sign_reduce_packer.sv
// Sign-reduction encoder: truncates signed lanes to R bits and packs
// W/R beats per output word, with per-block fit flag, fail count and bypass.
module sign_reduce_packer #(
    parameter int W = 16,
    parameter int R = 8,
    parameter int LANES = 4,
    parameter int BLK = 16,
    localparam int DW = LANES * W,
    localparam int CW = $clog2(BLK * LANES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] data_i,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic          bypass_i,
    output logic [DW-1:0] data_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic          last_o,
    output logic          flag_o,
    output logic [CW-1:0] fail_cnt_o
);

    localparam int P   = W / R;
    localparam int LR  = LANES * R;
    localparam int PKW = (P - 1) * LR;
    localparam int PCW = (P > 1) ? $clog2(P) : 1;
    localparam int BCW = (BLK > 1) ? $clog2(BLK) : 1;

    logic [BCW-1:0] bcnt;
    logic [PCW-1:0] pcnt;
    logic [CW-1:0]  fcnt;
    logic           mode;

    logic           blk_start;
    logic           b_last;
    logic           p_last;
    logic           mode_next;
    logic           loads;
    logic           accept;
    logic [CW-1:0]  beat_fails;
    logic [CW-1:0]  fcnt_next;
    logic [LR-1:0]  red;
    logic [DW-1:0]  packed_word;

    assign blk_start = (bcnt == '0);
    assign b_last    = (bcnt == BCW'(BLK - 1));
    assign p_last    = (pcnt == PCW'(P - 1));
    assign mode_next = blk_start ? bypass_i : mode;
    assign loads     = mode_next | p_last;
    assign ready_o   = ~loads | ~valid_o | ready_i;
    assign accept    = valid_i & ready_o;

    // A lane fits when everything from bit R-1 upward is pure sign extension.
    always_comb begin
        beat_fails = '0;
        red        = '0;
        for (int k = 0; k < LANES; k++) begin
            if (!(&data_i[k*W+R-1 +: W-R+1]) && (|data_i[k*W+R-1 +: W-R+1]))
                beat_fails = beat_fails + CW'(1);
            red[k*R +: R] = data_i[k*W +: R];
        end
    end

    assign fcnt_next = (blk_start ? '0 : fcnt) + beat_fails;

    generate
        if (P > 1) begin : g_pack
            logic [PKW-1:0] pack;

            // Earlier beats shift toward the MSBs as new ones arrive.
            assign packed_word = {pack, red};

            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    pack <= '0;
                else if (accept && !mode_next)
                    pack <= packed_word[PKW-1:0];
            end
        end else begin : g_nopack
            assign packed_word = red;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt       <= '0;
            pcnt       <= '0;
            fcnt       <= '0;
            mode       <= 1'b0;
            data_o     <= '0;
            valid_o    <= 1'b0;
            last_o     <= 1'b0;
            flag_o     <= 1'b0;
            fail_cnt_o <= '0;
        end else begin
            if (accept) begin
                bcnt <= b_last ? '0 : bcnt + BCW'(1);
                pcnt <= loads ? '0 : pcnt + PCW'(1);
                fcnt <= fcnt_next;
                mode <= mode_next;
            end
            if (accept && loads) begin
                data_o     <= mode_next ? data_i : packed_word;
                valid_o    <= 1'b1;
                last_o     <= b_last;
                fail_cnt_o <= b_last ? fcnt_next : '0;
                flag_o     <= b_last & ((fcnt_next != '0) | mode_next);
            end else if (ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sign_reduce_packer.sv
// Scoreboard bench for sign_reduce_packer: default 16->8 build plus
// a 32->8, 2-lane, 8-beat build checking the four-beat packing order.
module tb_sign_reduce_packer;

    typedef struct packed {
        logic [63:0] d;
        logic        l;
        logic        f;
        logic [6:0]  c;
    } exp_t;

    logic        clk;
    logic        rst;

    logic [63:0] d1;
    logic        v1, rdy_o1, byp1, vo1, ri1, last1, flag1;
    logic [63:0] dout1;
    logic [6:0]  fc1;

    logic [63:0] d2;
    logic        v2, rdy_o2, byp2, vo2, ri2, last2, flag2;
    logic [63:0] dout2;
    logic [4:0]  fc2;

    exp_t q1[$];
    exp_t q2[$];
    int   total = 0;
    int   bad = 0;

    localparam logic [63:0] A  = 64'h0001_0002_0003_0004;
    localparam logic [63:0] B  = 64'hFFFF_FFFE_0005_007F;
    localparam logic [63:0] W1 = 64'h0102_0304_FFFE_057F;

    sign_reduce_packer dut (
        .clk(clk), .rst(rst),
        .data_i(d1), .valid_i(v1), .ready_o(rdy_o1), .bypass_i(byp1),
        .data_o(dout1), .valid_o(vo1), .ready_i(ri1),
        .last_o(last1), .flag_o(flag1), .fail_cnt_o(fc1)
    );

    sign_reduce_packer #(.W(32), .R(8), .LANES(2), .BLK(8)) dut2 (
        .clk(clk), .rst(rst),
        .data_i(d2), .valid_i(v2), .ready_o(rdy_o2), .bypass_i(byp2),
        .data_o(dout2), .valid_o(vo2), .ready_i(ri2),
        .last_o(last2), .flag_o(flag2), .fail_cnt_o(fc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(logic [63:0] d, logic l, logic f, int c);
        exp_t e;
        e.d = d;
        e.l = l;
        e.f = f;
        e.c = 7'(c);
        return e;
    endfunction

    task automatic check_eq(string nm, logic [63:0] act, logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, want);
        end
    endtask

    // Monitors sample 1ns after the falling edge; a word transfers when
    // valid_o and ready_i are both high at the following rising edge.
    exp_t        m1a, m1e, m2a, m2e;
    logic        m1_hold = 1'b0;
    logic [63:0] m1_prev;

    initial forever begin
        @(negedge clk);
        #1;
        if (rst) begin
            m1_hold = 1'b0;
        end else begin
            if (m1_hold && vo1) begin
                total++;
                if (dout1 !== m1_prev) begin
                    bad++;
                    $display("FAIL hold1 data_o=%h want=%h", dout1, m1_prev);
                end
            end
            if (vo1 && ri1) begin
                m1a = mk(dout1, last1, flag1, int'(fc1));
                total++;
                if (q1.size() == 0) begin
                    bad++;
                    $display("FAIL out1 unexpected word d=%h", dout1);
                end else begin
                    m1e = q1.pop_front();
                    if (m1a !== m1e) begin
                        bad++;
                        $display("FAIL out1 got d=%h l=%b f=%b c=%0d want d=%h l=%b f=%b c=%0d",
                                 m1a.d, m1a.l, m1a.f, m1a.c, m1e.d, m1e.l, m1e.f, m1e.c);
                    end
                end
            end
            m1_hold = vo1 && !ri1;
            m1_prev = dout1;
        end
    end

    initial forever begin
        @(negedge clk);
        #1;
        if (!rst && vo2 && ri2) begin
            m2a = mk(dout2, last2, flag2, int'(fc2));
            total++;
            if (q2.size() == 0) begin
                bad++;
                $display("FAIL out2 unexpected word d=%h", dout2);
            end else begin
                m2e = q2.pop_front();
                if (m2a !== m2e) begin
                    bad++;
                    $display("FAIL out2 got d=%h l=%b f=%b c=%0d want d=%h l=%b f=%b c=%0d",
                             m2a.d, m2a.l, m2a.f, m2a.c, m2e.d, m2e.l, m2e.f, m2e.c);
                end
            end
        end
    end

    // Called just after a falling edge; returns just after the falling
    // edge that follows the accepting rising edge.
    task automatic send1(input logic [63:0] d, input logic b);
        int n = 0;
        d1 = d;
        byp1 = b;
        v1 = 1'b1;
        #1;
        while (!rdy_o1 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!rdy_o1) begin
            total++;
            bad++;
            $display("FAIL send1 timeout ready_o=%b want=1", rdy_o1);
        end
        @(negedge clk);
    endtask

    task automatic send2(input logic [63:0] d);
        int n = 0;
        d2 = d;
        byp2 = 1'b0;
        v2 = 1'b1;
        #1;
        while (!rdy_o2 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!rdy_o2) begin
            total++;
            bad++;
            $display("FAIL send2 timeout ready_o=%b want=1", rdy_o2);
        end
        @(negedge clk);
    endtask

    task automatic idle(int n);
        v1 = 1'b0;
        v2 = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic good_block();
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 1) q1.push_back(mk(W1, i == 15, 1'b0, 0));
            send1((i % 2 == 0) ? A : B, 1'b0);
        end
    endtask

    task automatic check_reset_outputs(string tag);
        check_eq({tag, " valid_o"}, 64'(vo1), 64'd0);
        check_eq({tag, " last_o"}, 64'(last1), 64'd0);
        check_eq({tag, " flag_o"}, 64'(flag1), 64'd0);
        check_eq({tag, " data_o"}, dout1, 64'd0);
        check_eq({tag, " fail_cnt_o"}, 64'(fc1), 64'd0);
        check_eq({tag, " ready_o"}, 64'(rdy_o1), 64'd1);
    endtask

    logic [63:0] beat;
    logic [63:0] word;

    initial begin
        rst = 1'b1;
        d1 = '0; v1 = 1'b0; byp1 = 1'b0; ri1 = 1'b1;
        d2 = '0; v2 = 1'b0; byp2 = 1'b0; ri2 = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // In-range block: eight identical packed words.
        good_block();
        idle(3);

        // Bypass block; bypass_i changes mid-block must be ignored.
        for (int i = 0; i < 16; i++) begin
            beat = 64'h0000_0001_0002_0003 + 64'(i);
            q1.push_back(mk(beat, i == 15, i == 15, 0));
            send1(beat, i != 7);
        end
        idle(3);

        // Compress block with two out-of-range lanes.
        for (int i = 0; i < 16; i++) begin
            beat = (i % 2 == 0) ? A : B;
            if (i == 5) beat = 64'hFFFF_0080_0005_007F;
            if (i == 12) beat = 64'h0001_0002_0003_FF7F;
            if (i % 2 == 1) begin
                word = W1;
                if (i == 5) word = 64'h0102_0304_FF80_057F;
                if (i == 13) word = 64'h0102_037F_FFFE_057F;
                q1.push_back(mk(word, i == 15, i == 15, (i == 15) ? 2 : 0));
            end
            send1(beat, 1'b0);
        end
        idle(3);

        // Backpressure right after the first word of a block.
        fork
            good_block();
            begin
                int n = 0;
                while (!vo1 && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                check_eq("bp first valid_o", 64'(vo1), 64'd1);
                ri1 = 1'b0;
                @(negedge clk);
                #1;
                check_eq("bp ready_o low", 64'(rdy_o1), 64'd0);
                check_eq("bp valid_i pending", 64'(v1), 64'd1);
                repeat (4) @(negedge clk);
                ri1 = 1'b1;
            end
        join
        idle(3);

        // Reset mid-block discards the partial block.
        q1.push_back(mk(W1, 1'b0, 1'b0, 0));
        q1.push_back(mk(W1, 1'b0, 1'b0, 0));
        for (int i = 0; i < 5; i++) send1((i % 2 == 0) ? A : B, 1'b0);
        v1 = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        good_block();
        idle(3);

        // Wide build: four beats per packed word.
        q2.push_back(mk(64'h1122_8344_55F6_7708, 1'b0, 1'b0, 0));
        q2.push_back(mk(64'h0001_FF02_0304_0506, 1'b1, 1'b1, 2));
        send2({32'h0000_0011, 32'h0000_0022});
        send2({32'hFFFF_FF83, 32'h0000_0044});
        send2({32'h0000_0055, 32'hFFFF_FFF6});
        send2({32'h0000_0077, 32'h0000_0008});
        send2({32'h0000_0100, 32'h0000_0001});
        send2({32'h7FFF_FFFF, 32'h0000_0002});
        send2({32'h0000_0003, 32'h0000_0004});
        send2({32'h0000_0005, 32'h0000_0006});
        idle(10);

        check_eq("q1 drained", 64'(q1.size()), 64'd0);
        check_eq("q2 drained", 64'(q2.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
